data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
// Parametrised, clocked data memory for the CPU load/store path. It serves LDR/STR
// accesses of byte, halfword or word size, with sign or zero extension on loads and
// a selectable endianness. Loads return data one cycle after the request, with a valid
// strobe. Requests that are misaligned, out of range or illegal are flagged on err.
// It sits between the execute-stage address/data outputs and the writeback mux.
// PARAMETERS
// DEPTH      16  number of 32-bit words; power of 2, >= 2
// ADDR_W     32  byte-address width; must be >= $clog2(DEPTH)+2
// BIG_ENDIAN 0   0: byte 0 in bits [7:0] of a word; 1: byte 0 in bits [31:24]
// PORTS
// clk        in   1       clock; all state updates on the rising edge
// rst        in   1       asynchronous, active-low reset
// addr       in   ADDR_W  byte address of the access
// wdata      in   32      store data, right-justified (byte in [7:0], half in [15:0])
// ld_en      in   1       load request this cycle
// st_en      in   1       store request this cycle
// size       in   2       00 byte, 01 halfword, 10 word, 11 reserved
// ld_signed  in   1       1: sign-extend a byte or halfword load; 0: zero-extend
// rdata      out  32      load result, extended to 32 bits
// rd_valid   out  1       rdata holds the result of the load issued in the previous cycle
// err        out  1       the request issued in the previous cycle was rejected
// BEHAVIOUR
// - Reset (rst=0, asynchronous): every memory word is 0; rdata=0, rd_valid=0, err=0.
// - Word index = addr[$clog2(DEPTH)+1:2]. If any addr bit above that field is nonzero,
//   the access is out of range.
// - Alignment: a halfword needs addr[0]=0; a word needs addr[1:0]=00.
// - Request legality: a request (ld_en|st_en) is legal only if all of these hold:
//   - exactly one of ld_en and st_en is high;
//   - size != 11;
//   - the address is aligned;
//   - the address is in range.
// - Illegal request: no memory word changes; the next cycle gives err=1 and rd_valid=0,
//   and rdata keeps its previous value.
// - Store: at the rising edge, only the addressed byte lanes are written. Lane mapping
//   follows BIG_ENDIAN; the other lanes of the word keep their value.
// - Load: at the rising edge the extracted and extended value is registered into rdata.
//   rd_valid=1 for exactly one cycle (latency 1).
//   - byte/half: lane is selected by addr[1:0] and BIG_ENDIAN;
//   - extension: per ld_signed;
//   - word: taken as-is.
// - No request: rd_valid=0 and err=0 next cycle; rdata holds its value.
// - A store followed by a load of the same address in the next cycle returns the new
//   data (write completes at the store edge).
// - Back-to-back loads are sustained, one per cycle.
// - rst asserted mid-access aborts it: a store in the reset cycle is not written,
//   and no rd_valid is produced.
// TESTING
// 1. Reset, then word load from 0x0 -> rd_valid=1 one cycle later, rdata=0x00000000.
// 2. Store word 0xDEADBEEF @0x4, then byte loads @0x4..0x7 (BIG_ENDIAN=0, unsigned)
//    -> 0xEF, 0xBE, 0xAD, 0xDE.
// 3. Store byte 0x80 @0x9, then load @0x9 -> 0xFFFFFF80 (signed), 0x00000080 (unsigned).
//    A word load @0x8 shows only lane 1 changed.
// 4. Store half 0x1234 @0xA with BIG_ENDIAN=1, then word load @0x8 -> bits [15:0]=0x1234.
//    The same bench with BIG_ENDIAN=0 gives bits [31:16]=0x1234.
// 5. Error cases, each followed by a word load confirming memory is unchanged:
//    - word load @0x2 -> err=1, rd_valid=0;
//    - store @(DEPTH*4) -> err=1;
//    - ld_en=st_en=1 -> err=1;
//    - size=11 -> err=1.
// 6. Drop rst mid-stream after storing 0x55 @0x0 -> outputs 0 immediately;
//    a load after reset returns 0.

Source files
------------

// File: rtl/data_memory.sv
// Clocked byte-addressable data memory for the load/store path.
// Byte/half/word accesses, selectable endianness, one-cycle load latency.
module data_memory #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [1:0]        size,
  input  logic              ld_signed,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = IDX_W + 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] hi;
  logic [1:0]        off;
  logic [1:0]        lane;
  logic              hsel;
  logic              in_range;
  logic              aligned;
  logic              is_b, is_h, is_w;
  logic              req, legal;
  logic              st_fire, ld_fire;
  logic [3:0]        be;
  logic [31:0]       wd_al;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [7:0]        b_val;
  logic [15:0]       h_val;
  logic [31:0]       ld_val;

  assign idx      = addr[OFF_W-1:2];
  assign hi       = addr >> OFF_W;
  assign in_range = (hi == '0);
  assign off      = addr[1:0];

  // Big-endian flips the lane order inside the word: byte b -> lane 3-b.
  assign lane = BIG_ENDIAN ? ~off : off;
  assign hsel = BIG_ENDIAN ? ~off[1] : off[1];

  assign is_b = (size == SZ_B);
  assign is_h = (size == SZ_H);
  assign is_w = (size == SZ_W);

  always_comb begin
    aligned = 1'b0;
    be      = 4'b0000;
    wd_al   = wdata;
    unique case (1'b1)
      is_b: begin
        aligned = 1'b1;
        be      = 4'b0001 << lane;
        wd_al   = {4{wdata[7:0]}};
      end
      is_h: begin
        aligned = ~off[0];
        be      = hsel ? 4'b1100 : 4'b0011;
        wd_al   = {2{wdata[15:0]}};
      end
      is_w: begin
        aligned = (off == 2'b00);
        be      = 4'b1111;
        wd_al   = wdata;
      end
      default: begin
        aligned = 1'b0;
        be      = 4'b0000;
        wd_al   = wdata;
      end
    endcase
  end

  assign req     = ld_en | st_en;
  assign legal   = (ld_en ^ st_en) & aligned & in_range;
  assign st_fire = st_en & legal;
  assign ld_fire = ld_en & legal;

  assign rd_word = mem_q[idx];
  assign shifted = rd_word >> {lane, 3'b000};
  assign b_val   = shifted[7:0];
  assign h_val   = hsel ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_val = rd_word;
    unique case (1'b1)
      is_b:    ld_val = {{24{ld_signed & b_val[7]}}, b_val};
      is_h:    ld_val = {{16{ld_signed & h_val[15]}}, h_val};
      default: ld_val = rd_word;
    endcase
  end

  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      mem_d[w] = mem_q[w];
    end
    if (st_fire) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem_d[idx][8*l +: 8] = wd_al[8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d    = ld_fire ? ld_val : rdata_q;
    rd_valid_d = ld_fire;
    err_d      = req & ~legal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory, little- and big-endian instances
// driven in lockstep from one stimulus stream.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ld_en, st_en, ld_signed;
  logic [1:0]  size;
  logic [31:0] rdata0, rdata1;
  logic        rv0, rv1, err0, err1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d0;
    logic [31:0] d1;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last0, last1;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(16), .ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .ld_en(ld_en), .st_en(st_en), .size(size),
    .ld_signed(ld_signed), .rdata(rdata0),
    .rd_valid(rv0), .err(err0)
  );

  data_memory #(.DEPTH(16), .ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .ld_en(ld_en), .st_en(st_en), .size(size),
    .ld_signed(ld_signed), .rdata(rdata1),
    .rd_valid(rv1), .err(err1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, ".le.rdata"}, rdata0, 32'h0);
    chk({tag, ".le.valid"}, {31'b0, rv0}, 32'h0);
    chk({tag, ".le.err"},   {31'b0, err0}, 32'h0);
    chk({tag, ".be.rdata"}, rdata1, 32'h0);
    chk({tag, ".be.valid"}, {31'b0, rv1}, 32'h0);
    chk({tag, ".be.err"},   {31'b0, err1}, 32'h0);
  endtask

  task automatic drive(logic l, logic s, logic [31:0] a,
                       logic [31:0] wd, logic [1:0] sz, logic sg,
                       logic ev, logic ee, logic [31:0] x0,
                       logic [31:0] x1, string tag);
    exp_t t;
    exp_t got;
    @(negedge clk);
    ld_en = l; st_en = s; addr = a;
    wdata = wd; size = sz; ld_signed = sg;
    if (ev) begin
      last0 = x0;
      last1 = x1;
    end
    t.v = ev; t.e = ee; t.d0 = last0; t.d1 = last1; t.tag = tag;
    sb.push_back(t);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".le.rdata"}, rdata0, got.d0);
    chk({got.tag, ".le.valid"}, {31'b0, rv0}, {31'b0, got.v});
    chk({got.tag, ".le.err"},   {31'b0, err0}, {31'b0, got.e});
    chk({got.tag, ".be.rdata"}, rdata1, got.d1);
    chk({got.tag, ".be.valid"}, {31'b0, rv1}, {31'b0, got.v});
    chk({got.tag, ".be.err"},   {31'b0, err1}, {31'b0, got.e});
    ld_en = 1'b0;
    st_en = 1'b0;
  endtask

  task automatic st(logic [31:0] a, logic [31:0] wd,
                    logic [1:0] sz, string tag);
    drive(1'b0, 1'b1, a, wd, sz, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
  endtask

  task automatic ld(logic [31:0] a, logic [1:0] sz, logic sg,
                    logic [31:0] x0, logic [31:0] x1, string tag);
    drive(1'b1, 1'b0, a, 32'h0, sz, sg, 1'b1, 1'b0, x0, x1, tag);
  endtask

  task automatic bad(logic l, logic s, logic [31:0] a,
                     logic [31:0] wd, logic [1:0] sz, string tag);
    drive(l, s, a, wd, sz, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, tag);
  endtask

  initial begin
    rst = 1'b0;
    addr = '0; wdata = '0; size = 2'b10;
    ld_en = 1'b0; st_en = 1'b0; ld_signed = 1'b0;
    last0 = '0; last1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b1;

    ld(32'h0, 2'b10, 1'b0, 32'h0, 32'h0, "ld0");

    st(32'h4, 32'hDEADBEEF, 2'b10, "st_w4");
    ld(32'h4, 2'b00, 1'b0, 32'hEF, 32'hDE, "ldb4");
    ld(32'h5, 2'b00, 1'b0, 32'hBE, 32'hAD, "ldb5");
    ld(32'h6, 2'b00, 1'b0, 32'hAD, 32'hBE, "ldb6");
    ld(32'h7, 2'b00, 1'b0, 32'hDE, 32'hEF, "ldb7");
    ld(32'h4, 2'b01, 1'b1, 32'hFFFFBEEF, 32'hFFFFDEAD, "ldh4s");

    st(32'h9, 32'hFFFFFF80, 2'b00, "st_b9");
    ld(32'h9, 2'b00, 1'b1, 32'hFFFFFF80, 32'hFFFFFF80, "ldb9s");
    ld(32'h9, 2'b00, 1'b0, 32'h00000080, 32'h00000080, "ldb9u");
    ld(32'h8, 2'b10, 1'b0, 32'h00008000, 32'h00800000, "ldw8a");

    st(32'hA, 32'hABCD1234, 2'b01, "st_hA");
    ld(32'h8, 2'b10, 1'b0, 32'h12348000, 32'h00801234, "ldw8b");
    ld(32'hA, 2'b01, 1'b0, 32'h00001234, 32'h00001234, "ldhA");
    ld(32'h8, 2'b01, 1'b1, 32'hFFFF8000, 32'h00000080, "ldh8s");

    bad(1'b1, 1'b0, 32'h2, 32'h0, 2'b10, "e_mis_w");
    ld(32'h0, 2'b10, 1'b0, 32'h0, 32'h0, "chk_e1");
    bad(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 2'b10, "e_range");
    ld(32'h0, 2'b10, 1'b0, 32'h0, 32'h0, "chk_e2");
    bad(1'b1, 1'b1, 32'h4, 32'h0, 2'b10, "e_both");
    ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "chk_e3");
    bad(1'b0, 1'b1, 32'h4, 32'h0, 2'b11, "e_size");
    ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "chk_e4");
    bad(1'b0, 1'b1, 32'h5, 32'h0, 2'b01, "e_mis_h");
    ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "chk_e5");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0,
          1'b0, 1'b0, 32'h0, 32'h0, "idle");

    st(32'h0, 32'h55, 2'b10, "st_55");
    ld(32'h0, 2'b10, 1'b0, 32'h55, 32'h55, "ld55");

    @(negedge clk);
    st_en = 1'b1; addr = 32'hC; wdata = 32'hAAAA5555; size = 2'b10;
    #2;
    rst = 1'b0;
    #1;
    chk_idle("midrst");
    @(posedge clk);
    #1;
    st_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last0 = '0; last1 = '0;
    ld(32'h0, 2'b10, 1'b0, 32'h0, 32'h0, "post0");
    ld(32'hC, 2'b10, 1'b0, 32'h0, 32'h0, "postC");
    ld(32'h4, 2'b10, 1'b0, 32'h0, 32'h0, "post4");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
